bcd2bin: RTL and testbench

//  Sequential 4-digit BCD-to-binary converter (reverse double-dabble); the inverse of the

---
 rtl/bcd2bin.sv | 119 +++++++++++
 tb/tb_bcd2bin.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD-to-binary converter (reverse double-dabble).
// Uses the same start/ready/done_tick handshake as the binary-to-BCD converter.
module bcd2bin #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       bcd3,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd0,
    output logic             ready,
    output logic             done_tick,
    output logic             err,
    output logic [BIN_W-1:0] bin
);

    localparam int W_W   = 16 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_W-1:0]     w_q, w_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [W_W-1:0]     shift_w;
    logic [W_W-1:0]     corr_w;
    logic [3:0]         digit_in [4];
    logic [3:0]         digit_bad;

    assign digit_in[0] = bcd0;
    assign digit_in[1] = bcd1;
    assign digit_in[2] = bcd2;
    assign digit_in[3] = bcd3;

    // One shift step: the units-digit LSB drops into the binary field MSB,
    // then any BCD field that picked up a carried "10" (value >= 8) is fixed by -3.
    assign shift_w             = w_q >> 1;
    assign corr_w[BIN_W-1:0]   = shift_w[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign corr_w[BIN_W+4*gi +: 4] = (shift_w[BIN_W+4*gi +: 4] >= 4'd8)
                                             ? shift_w[BIN_W+4*gi +: 4] - 4'd3
                                             : shift_w[BIN_W+4*gi +: 4];
            assign digit_bad[gi] = (digit_in[gi] > 4'd9);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        n_d     = n_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (|digit_bad) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        w_d     = {bcd3, bcd2, bcd1, bcd0, {BIN_W{1'b0}}};
                        n_d     = CNT_W'(BIN_W);
                        state_d = OP;
                    end
                end
            end
            OP: begin
                w_d = corr_w;
                n_d = n_q - 1'b1;
                if (n_q == CNT_W'(1)) begin
                    bin_d   = corr_w[BIN_W-1:0];
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            n_q     <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            n_q     <= n_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = done_q;
    assign err       = err_q;
    assign bin       = bin_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed-vector bench for bcd2bin: latency, results, error path,
// start-during-busy rejection and mid-conversion reset.
module tb_bcd2bin;

    localparam int BIN_W = 14;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [3:0]       bcd3, bcd2, bcd1, bcd0;
    logic             ready;
    logic             done_tick;
    logic             err;
    logic [BIN_W-1:0] bin;

    int n_total = 0;
    int n_pass  = 0;

    bcd2bin #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .ready     (ready),
        .done_tick (done_tick),
        .err       (err),
        .bin       (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Start one conversion, optionally re-pulse start at edge pulse_at,
    // and watch done_tick over a fixed window of edges.
    task automatic run_conv(input string tag, input logic [15:0] digits, input int pulse_at,
                            input logic [13:0] exp_bin, input logic exp_err, input int exp_edge);
        int first;
        int cnt;
        first = -1;
        cnt   = 0;
        @(negedge clk);
        {bcd3, bcd2, bcd1, bcd0} = digits;
        start = 1'b1;
        chk({tag, " ready_before"}, 32'(ready), 32'd1);
        for (int e = 0; e <= BIN_W + 3; e++) begin
            @(posedge clk);
            #1;
            if (done_tick) begin
                cnt++;
                if (first < 0) first = e;
            end
            if (e == 0) begin
                start = 1'b0;
                {bcd3, bcd2, bcd1, bcd0} = 16'h5555;
            end
            if (e == 1) chk({tag, " ready_e1"}, 32'(ready), 32'(exp_edge == 0));
            if (e == pulse_at) start = 1'b1;
            if (e == pulse_at + 2) start = 1'b0;
        end
        chk({tag, " done_edge"}, 32'(first), 32'(exp_edge));
        chk({tag, " done_count"}, 32'(cnt), 32'd1);
        chk({tag, " bin"}, 32'(bin), 32'(exp_bin));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " ready_after"}, 32'(ready), 32'd1);
        $display("conv %s digits=%h bin=%0d err=%0d done_edge=%0d", tag, digits, bin, err, first);
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        start   = 1'b0;
        {bcd3, bcd2, bcd1, bcd0} = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst done", 32'(done_tick), 32'd0);
        chk("rst bin", 32'(bin), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done_tick || !ready) cnt++;
        end
        chk("idle stays", 32'(cnt), 32'd0);
        $display("reset ready=%0d bin=%0d err=%0d", ready, bin, err);

        run_conv("9999", 16'h9999, -1, 14'h270F, 1'b0, BIN_W);
        run_conv("1234", 16'h1234, -1, 14'd1234, 1'b0, BIN_W);
        run_conv("0000", 16'h0000, -1, 14'd0,    1'b0, BIN_W);
        run_conv("0108", 16'h0108, -1, 14'd108,  1'b0, BIN_W);
        run_conv("bad",  16'h00A0, -1, 14'd0,    1'b1, 0);
        run_conv("0042", 16'h0042, -1, 14'd42,   1'b0, BIN_W);
        run_conv("busy", 16'h1234, 3,  14'd1234, 1'b0, BIN_W);

        // Reset during OP cycle 7: no done_tick, outputs cleared immediately.
        @(negedge clk);
        {bcd3, bcd2, bcd1, bcd0} = 16'h9876;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst ready", 32'(ready), 32'd1);
        chk("midrst bin", 32'(bin), 32'd0);
        chk("midrst err", 32'(err), 32'd0);
        chk("midrst done", 32'(done_tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < BIN_W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done_tick) cnt++;
        end
        chk("midrst no_done", 32'(cnt), 32'd0);
        chk("midrst bin_held", 32'(bin), 32'd0);
        $display("midreset ready=%0d bin=%0d err=%0d", ready, bin, err);

        run_conv("9999b", 16'h9999, -1, 14'd9999, 1'b0, BIN_W);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
